// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_tx
// Purpose  : FIFO-buffered UART frame generator (start, data LSB first,
//            optional parity, 1 or 2 stop bits) with valid/ready input.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 864,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 3,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          Tx_D,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int C_AW = $clog2(FIFO_DEPTH);
    localparam int C_CW = $clog2(CLKS_PER_BIT);
    localparam int C_BW = $clog2(DATA_BITS);

    localparam logic [C_CW-1:0] C_CYC_LAST  = C_CW'(CLKS_PER_BIT - 1);
    localparam logic [C_CW-1:0] C_CYC_PRE   = C_CW'(CLKS_PER_BIT - 2);
    localparam logic [C_BW-1:0] C_BIT_LAST  = C_BW'(DATA_BITS - 1);
    localparam logic            C_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [C_AW:0]   C_FULL      = (C_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [C_AW-1:0]      wr_ptr_q;
    logic [C_AW-1:0]      rd_ptr_q;
    logic [C_AW:0]        count_q;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    assign tx_ready   = (count_q != C_FULL);
    assign fifo_count = count_q;
    assign empty      = (count_q == '0);
    assign push       = tx_valid && tx_ready;
    assign head       = mem_q[rd_ptr_q];
    assign head_par   = (PARITY_MODE == 1) ? (^head)  :
                        (PARITY_MODE == 2) ? ~(^head) : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [C_CW-1:0]      cyc_q, cyc_d;
    logic [C_BW-1:0]      bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 done_q, done_d;
    logic                 cyc_last;
    logic                 load;

    assign cyc_last = (cyc_q == C_CYC_LAST);

    // tx_d always carries the line level of the bit the FSM is moving into,
    // so the serial output stays a plain register with no output decode.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        cyc_d   = cyc_last ? '0 : cyc_q + 1'b1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                load  = !empty;
            end
            S_START: begin
                if (cyc_last) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (cyc_last) begin
                    if (bit_q == C_BIT_LAST) begin
                        if (PARITY_MODE != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (cyc_last) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                done_d = (stop_q == C_STOP_LAST) && (cyc_q == C_CYC_PRE);
                if (cyc_last) begin
                    if (stop_q == C_STOP_LAST) begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        load    = !empty;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = head_par;
            cyc_d   = '0;
            bit_d   = '0;
            state_d = S_START;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            cyc_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
        end
    end

    assign Tx_D       = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_tx
// Purpose  : Self-checking bench for uart_frame_tx across five configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // dut0 defaults; dut1 fast; dut2 even; dut3 odd; dut4 7 data bits, 2 stop
    int cfg_cpb [5] = '{864, 16, 16, 16, 16};
    int cfg_db  [5] = '{8, 8, 8, 8, 7};
    int cfg_pm  [5] = '{3, 3, 1, 2, 3};
    int cfg_sb  [5] = '{1, 1, 1, 1, 2};

    logic [4:0] dv;
    logic [8:0] ddata [5];
    wire  [4:0] dline, dbusy, ddone, dready;
    wire  [2:0] dcnt [5];

    uart_frame_tx u_dut0 (
        .clk(clk), .reset(reset), .tx_data(ddata[0][7:0]), .tx_valid(dv[0]),
        .tx_ready(dready[0]), .Tx_D(dline[0]), .busy(dbusy[0]),
        .frame_done(ddone[0]), .fifo_count(dcnt[0]));

    uart_frame_tx #(.CLKS_PER_BIT(16)) u_dut1 (
        .clk(clk), .reset(reset), .tx_data(ddata[1][7:0]), .tx_valid(dv[1]),
        .tx_ready(dready[1]), .Tx_D(dline[1]), .busy(dbusy[1]),
        .frame_done(ddone[1]), .fifo_count(dcnt[1]));

    uart_frame_tx #(.CLKS_PER_BIT(16), .PARITY_MODE(1)) u_dut2 (
        .clk(clk), .reset(reset), .tx_data(ddata[2][7:0]), .tx_valid(dv[2]),
        .tx_ready(dready[2]), .Tx_D(dline[2]), .busy(dbusy[2]),
        .frame_done(ddone[2]), .fifo_count(dcnt[2]));

    uart_frame_tx #(.CLKS_PER_BIT(16), .PARITY_MODE(2)) u_dut3 (
        .clk(clk), .reset(reset), .tx_data(ddata[3][7:0]), .tx_valid(dv[3]),
        .tx_ready(dready[3]), .Tx_D(dline[3]), .busy(dbusy[3]),
        .frame_done(ddone[3]), .fifo_count(dcnt[3]));

    uart_frame_tx #(.CLKS_PER_BIT(16), .DATA_BITS(7), .STOP_BITS(2)) u_dut4 (
        .clk(clk), .reset(reset), .tx_data(ddata[4][6:0]), .tx_valid(dv[4]),
        .tx_ready(dready[4]), .Tx_D(dline[4]), .busy(dbusy[4]),
        .frame_done(ddone[4]), .fifo_count(dcnt[4]));

    typedef struct {
        int         idx;
        logic [8:0] data;
    } sb_t;

    typedef struct {
        int         idx;
        logic [8:0] data;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    sb_t        sb [$];
    logic [8:0] words [$];
    int         cnt_log [$];
    vec_t       vecs [8];

    int n_tests = 0;
    int n_fail  = 0;
    int frames    [5] = '{default: 0};
    int b2b       [5] = '{default: 0};
    int last_par  [5] = '{default: 0};
    int last_done [5] = '{default: 0};
    logic saw_full;
    int   resume_cnt;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic exp_parity(input int idx, input logic [8:0] d);
        int ones = 0;
        for (int i = 0; i < cfg_db[idx]; i++) if (d[i]) ones++;
        case (cfg_pm[idx])
            1:       return (ones % 2) == 1;
            2:       return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Decodes frames on one serial line; every sample is checked against the
    // bit the scoreboard word implies, not just the mid-bit sample.
    task automatic monitor(input int idx);
        int         gap, cpb, db, total, k, serr, derr, berr, dpos;
        logic [15:0] eb;
        logic [8:0] ed, od;
        logic       op, aborted;
        sb_t        e;
        cpb = cfg_cpb[idx];
        db  = cfg_db[idx];
        gap = 1000000;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                gap = 1000000;
                continue;
            end
            if (dline[idx] !== 1'b0) begin
                if (gap == 0) check("busy_drop", idx, 32'(dbusy[idx]), 0);
                gap++;
                continue;
            end
            frames[idx]++;
            if (gap == 0) b2b[idx]++;
            if (sb.size() == 0) begin
                check("unexpected_frame", idx, 1, 0);
                ed = '0;
            end else begin
                e = sb.pop_front();
                check("sb_dut", idx, e.idx, idx);
                ed = e.data;
            end
            eb    = '1;
            eb[0] = 1'b0;
            for (int i = 0; i < db; i++) eb[1 + i] = ed[i];
            if (cfg_pm[idx] != 0) eb[1 + db] = exp_parity(idx, ed);
            total = (1 + db + ((cfg_pm[idx] != 0) ? 1 : 0) + cfg_sb[idx]) * cpb;
            serr = 0; derr = 0; berr = 0; dpos = 0; aborted = 1'b0; od = '0; op = 1'b0;
            for (int n = 1; n <= total; n++) begin
                if (n > 1) begin @(posedge clk); #1; end
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
                k = (n - 1) / cpb;
                if (dline[idx] !== eb[k]) serr++;
                if (ddone[idx] === 1'b1 && dpos == 0) dpos = n;
                if (ddone[idx] !== (n == total)) derr++;
                if (dbusy[idx] !== 1'b1) berr++;
                if ((n - 1) % cpb == cpb / 2) begin
                    if (k >= 1 && k <= db) od[k - 1] = dline[idx];
                    if (cfg_pm[idx] != 0 && k == db + 1) op = dline[idx];
                end
            end
            if (aborted) begin
                gap = 1000000;
            end else begin
                check("serial_bits", idx, serr, 0);
                check("frame_done_pos", idx, derr, 0);
                check("busy_in_frame", idx, berr, 0);
                check("data", idx, 32'(od), 32'(ed));
                last_par[idx]  = int'(op);
                last_done[idx] = dpos;
                gap = 0;
            end
        end
    endtask

    // Holds tx_valid while words remain; a word enters the scoreboard on the
    // cycle its handshake completes.
    task automatic stream(input int idx, input int budget);
        int   c = 0;
        logic stalled = 1'b0;
        saw_full   = 1'b0;
        resume_cnt = -1;
        cnt_log.delete();
        @(negedge clk);
        while (words.size() > 0 && c < budget) begin
            dv[idx]    = 1'b1;
            ddata[idx] = words[0];
            if (dready[idx]) begin
                if (stalled) resume_cnt = int'(dcnt[idx]);
                stalled = 1'b0;
                sb.push_back('{idx: idx, data: words[0]});
                void'(words.pop_front());
            end else begin
                stalled = 1'b1;
                if (dcnt[idx] == 3'd4) saw_full = 1'b1;
            end
            @(negedge clk);
            cnt_log.push_back(int'(dcnt[idx]));
            c++;
        end
        dv[idx] = 1'b0;
        check("stream_done", idx, words.size(), 0);
        words.delete();
    endtask

    task automatic wait_idle(input int idx, input int budget);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(dbusy[idx] == 1'b0 && dcnt[idx] == 3'd0 && sb.size() == 0) && c < budget);
        check("idle_timeout", idx, 32'(c < budget), 1);
    endtask

    task automatic wait_done(input int idx, input int budget);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (ddone[idx] !== 1'b1 && c < budget);
        check("done_timeout", idx, 32'(c < budget), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, f0;
        int exp_cnt [4] = '{1, 1, 2, 3};

        reset = 1'b1;
        dv    = '0;
        for (int i = 0; i < 5; i++) ddata[i] = '0;

        vecs[0] = '{0, 9'h0EE, 1'b0, 9504};
        vecs[1] = '{2, 9'h0A7, 1'b1, 176};
        vecs[2] = '{3, 9'h0A7, 1'b0, 176};
        vecs[3] = '{4, 9'h055, 1'b0, 176};
        vecs[4] = '{1, 9'h000, 1'b0, 176};
        vecs[5] = '{2, 9'h000, 1'b0, 176};
        vecs[6] = '{3, 9'h000, 1'b1, 176};
        vecs[7] = '{2, 9'h0FF, 1'b0, 176};

        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
            monitor(4);
        join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i += 4) begin
            check("rst_txd", i, 32'(dline[i]), 1);
            check("rst_ready", i, 32'(dready[i]), 1);
            check("rst_busy", i, 32'(dbusy[i]), 0);
            check("rst_done", i, 32'(ddone[i]), 0);
            check("rst_count", i, 32'(dcnt[i]), 0);
        end
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            words.push_back(vecs[i].data);
            stream(vecs[i].idx, 10);
            wait_idle(vecs[i].idx, 12000);
            check("parity_bit", vecs[i].idx, last_par[vecs[i].idx], 32'(vecs[i].exp_par));
            check("frame_len", vecs[i].idx, last_done[vecs[i].idx], vecs[i].exp_len);
        end

        b0 = b2b[1];
        words = '{9'h05E, 9'h0C4, 9'h037, 9'h075};
        stream(1, 20);
        for (int j = 0; j < 4; j++) check("count_push", 1, cnt_log[j], exp_cnt[j]);
        for (int j = 0; j < 3; j++) begin
            wait_done(1, 400);
            @(negedge clk);
            check("count_pop", 1, 32'(dcnt[1]), 2 - j);
        end
        wait_done(1, 400);
        @(negedge clk);
        check("busy_after_last", 1, 32'(dbusy[1]), 0);
        wait_idle(1, 400);
        check("back_to_back", 1, b2b[1] - b0, 3);

        f0 = frames[2];
        words = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020};
        stream(2, 2000);
        check("full_stall", 2, 32'(saw_full), 1);
        check("resume_count", 2, resume_cnt, 3);
        wait_idle(2, 2000);
        check("frames_sent", 2, frames[2] - f0, 6);

        f0 = frames[1];
        words = '{9'h011, 9'h022, 9'h033};
        stream(1, 10);
        repeat (70) @(negedge clk);
        check("mid_busy", 1, 32'(dbusy[1]), 1);
        check("mid_queued", 1, 32'(dcnt[1]), 2);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_txd", 1, 32'(dline[1]), 1);
        check("rstmid_busy", 1, 32'(dbusy[1]), 0);
        check("rstmid_count", 1, 32'(dcnt[1]), 0);
        check("rstmid_done", 1, 32'(ddone[1]), 0);
        check("rstmid_ready", 1, 32'(dready[1]), 1);
        repeat (600) @(negedge clk);
        check("no_more_frames", 1, frames[1] - f0, 1);
        check("line_idle", 1, 32'(dline[1]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART serial frame generator. It accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and drives frames onto a single serial line: start bit, data LSB first, optional parity bit, then 1 or 2 stop bits. It is the synthesizable, configurable successor to the fixed 8-data/zero-parity/1-stop, 864-clock-per-bit frame stimulus used for the receive path. It feeds the UART receiver / FSM / RS decoder chain in loopback, and serves as the SoC's transmit side.

## Interface
- CLKS_PER_BIT, 864, clock cycles per serial bit (≥ 2).
- DATA_BITS, 8, data bits per frame (5–9).
- PARITY_MODE, 3, 0 = none, 1 = even, 2 = odd, 3 = space (parity bit always 0).
- STOP_BITS, 1, number of stop bits (1 or 2).
- FIFO_DEPTH, 4, input FIFO entries (power of 2, ≥ 2).

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept; equals !full.
- Tx_D  out  1  serial line; idle high.
- busy  out  1  a frame is on the line (state ≠ IDLE).
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words buffered, excluding the word being sent.

## Operation
- Push: on a rising edge with tx_valid && tx_ready, tx_data is written to the FIFO.
- A push while full is not performed; tx_ready = 0 in that case, even if a pop occurs in the same cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE, FIFO non-empty:
  - pop the word into the shift register;
  - compute parity over the popped word;
  - clear the bit counter and cycle counter;
  - go to START.
- START: Tx_D = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: Tx_D = shift_reg[0], held for CLKS_PER_BIT cycles per bit, then shift right. After DATA_BITS bits, go to PARITY if PARITY_MODE ≠ 0, else go to STOP.
- PARITY: one bit time.
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
  - Space: 0.
- STOP: Tx_D = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - frame_done pulses on the final cycle.
  - On that cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Cycle counter width: $clog2(CLKS_PER_BIT); wraps to 0 at CLKS_PER_BIT−1.
- Simultaneous push and pop on the same edge (not full): fifo_count is unchanged; both operations take effect.
- Reset mid-frame: on the reset edge,
  - Tx_D = 1, state = IDLE;
  - FIFO flushed (pointers and count = 0);
  - the partial frame is abandoned;
  - no frame_done pulse.

## Timing
- Reset values: Tx_D = 1, tx_ready = 1, busy = 0, frame_done = 0, fifo_count = 0, state IDLE.
- Tx_D, busy and frame_done are registered outputs. tx_ready and fifo_count are derived from registered FIFO state.
- Latency, idle block: word pushed at edge N → popped at edge N+1 → Tx_D = 0 from edge N+1. busy = 1 from N+1.
- Frame length: (1 + DATA_BITS + (PARITY_MODE ≠ 0) + STOP_BITS) × CLKS_PER_BIT cycles.
  - Defaults: 11 × 864 = 9504 cycles = 95.04 µs at 100 MHz.
- Back-to-back frames: the next start bit begins on the cycle after frame_done, with zero idle cycles.
- Every bit boundary is exactly CLKS_PER_BIT cycles apart; no jitter.

## Test plan
- Single word, defaults, tx_data = 8'hEE, Tx_D sampled at mid-bit → 0, 0,1,1,1,0,1,1,1, 0, 1. frame_done is high exactly 9504 cycles after Tx_D falls, and busy drops the next cycle.
- PARITY_MODE = 1 with 8'hA7, then PARITY_MODE = 2 with 8'hA7 → parity bit 1 (even), then 0 (odd). Frame = 11 bit times.
- Push 8'h5E, 8'hC4, 8'h37, 8'h75 on consecutive cycles → four contiguous frames with no high gap between a stop bit and the next start bit. fifo_count goes 1, 1, 2, 3, then decrements at each pop.
- Hold tx_valid high with 6 words while the first frame is sending (FIFO_DEPTH = 4) → tx_ready = 0 once fifo_count = 4. Stalled words are accepted only after the next pop, and no word is lost or duplicated.
- Assert reset for one cycle in the middle of data bit 3 with 2 words queued → next edge Tx_D = 1, busy = 0, fifo_count = 0, and no further frames are sent.
- STOP_BITS = 2, DATA_BITS = 7, CLKS_PER_BIT = 16, tx_data = 7'h55 → stop high for 32 cycles, and total frame length = 11 × 16 = 176 cycles with parity (space) included.
